// File: rtl/lsu.sv
// Load/store unit: single outstanding data-bus access with grant/rvalid handshake and wait timeout.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete with an error instead of being aligned.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lsu_enable_ip,
   input  logic        lsu_we_ip,
   input  logic [1:0]  lsu_size_ip,
   input  logic        lsu_sign_ext_ip,
   input  logic [31:0] alu_result_ip,
   input  logic        alu_valid_ip,
   input  logic [31:0] lsu_wdata_ip,
   output logic        data_req_op,
   output logic [31:0] data_addr_op,
   output logic        data_we_op,
   output logic [3:0]  data_be_op,
   output logic [31:0] data_wdata_op,
   input  logic        data_gnt_ip,
   input  logic        data_rvalid_ip,
   input  logic [31:0] data_rdata_ip,
   output logic [31:0] lsu_rdata_op,
   output logic        lsu_valid_op,
   output logic        lsu_err_op,
   output logic        lsu_busy_op
);

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_t;

   // Abort happens on the edge that would take the counter to TIMEOUT_CYCLES.
   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nx;
   logic [7:0]  cnt, cnt_nx;
   logic        capture, done, fail, trap;

   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [3:0]  be_q;
   logic [1:0]  size_q, off_q;
   logic        we_q, sign_q, valid_q, err_q;

   logic [1:0]  off_new;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_data;

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap = ((lsu_size_ip == 2'b01) && alu_result_ip[0]) ||
                 (lsu_size_ip[1] && (alu_result_ip[1:0] != 2'b00));
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      off_new   = '0;
      be_new    = '1;
      wdata_new = lsu_wdata_ip;
      case (lsu_size_ip)
         2'b00: begin
            off_new   = alu_result_ip[1:0];
            be_new    = 4'b0001 << alu_result_ip[1:0];
            wdata_new = {4{lsu_wdata_ip[7:0]}};
         end
         2'b01: begin
            off_new   = {alu_result_ip[1], 1'b0};
            be_new    = 4'b0011 << {alu_result_ip[1], 1'b0};
            wdata_new = {2{lsu_wdata_ip[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      case (off_q)
         2'd1:    rd_byte = data_rdata_ip[15:8];
         2'd2:    rd_byte = data_rdata_ip[23:16];
         2'd3:    rd_byte = data_rdata_ip[31:24];
         default: rd_byte = data_rdata_ip[7:0];
      endcase
      rd_half = off_q[1] ? data_rdata_ip[31:16] : data_rdata_ip[15:0];
      case (size_q)
         2'b00:   load_data = {{24{sign_q & rd_byte[7]}}, rd_byte};
         2'b01:   load_data = {{16{sign_q & rd_half[15]}}, rd_half};
         default: load_data = data_rdata_ip;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      capture  = 1'b0;
      done     = 1'b0;
      fail     = 1'b0;
      case (state)
         IDLE: begin
            if (lsu_enable_ip && alu_valid_ip) begin
               if (trap) begin
                  done = 1'b1;
                  fail = 1'b1;
               end else begin
                  capture  = 1'b1;
                  state_nx = WAIT_GNT;
               end
            end
         end
         WAIT_GNT: begin
            if (data_gnt_ip) begin
               state_nx = WAIT_RVALID;
            end else if (cnt == LAST_CNT) begin
               state_nx = IDLE;
               done     = 1'b1;
               fail     = 1'b1;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         WAIT_RVALID: begin
            if (data_rvalid_ip) begin
               state_nx = IDLE;
               done     = 1'b1;
            end else if (cnt == LAST_CNT) begin
               state_nx = IDLE;
               done     = 1'b1;
               fail     = 1'b1;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         size_q  <= '0;
         off_q   <= '0;
         sign_q  <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (capture) begin
            addr_q  <= {alu_result_ip[31:2], 2'b00};
            wdata_q <= wdata_new;
            be_q    <= be_new;
            we_q    <= lsu_we_ip;
            size_q  <= lsu_size_ip;
            off_q   <= off_new;
            sign_q  <= lsu_sign_ext_ip;
         end
         valid_q <= done;
         if (done) begin
            err_q   <= fail;
            rdata_q <= (fail || we_q) ? '0 : load_data;
         end
      end
   end

   assign data_req_op   = (state == WAIT_GNT);
   assign lsu_busy_op   = (state != IDLE);
   assign data_addr_op  = addr_q;
   assign data_we_op    = we_q;
   assign data_be_op    = be_q;
   assign data_wdata_op = wdata_q;
   assign lsu_valid_op  = valid_q;
   assign lsu_err_op    = err_q;
   assign lsu_rdata_op  = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomised and directed bench for lsu against a transaction-level reference model.
module tb_lsu;

   localparam int unsigned TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0, we_i = 1'b0, sg_i = 1'b0, av = 1'b0;
   logic [1:0]  sz_i = '0;
   logic [31:0] alu = '0, wd_i = '0, rd_i = '0;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic        data_req_op, data_we_op, lsu_valid_op, lsu_err_op, lsu_busy_op;
   logic [31:0] data_addr_op, data_wdata_op, lsu_rdata_op;
   logic [3:0]  data_be_op;

   int vec = 0;
   int errs = 0;

   typedef struct {
      int          reqc;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        we;
      bit          stable;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          busy_bad;
      logic        post_valid;
      logic [31:0] post_rdata;
      logic        post_err;
   } obs_t;

   always #5 clk = ~clk;

   lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .lsu_enable_ip(en), .lsu_we_ip(we_i), .lsu_size_ip(sz_i), .lsu_sign_ext_ip(sg_i),
      .alu_result_ip(alu), .alu_valid_ip(av), .lsu_wdata_ip(wd_i),
      .data_req_op(data_req_op), .data_addr_op(data_addr_op), .data_we_op(data_we_op),
      .data_be_op(data_be_op), .data_wdata_op(data_wdata_op),
      .data_gnt_ip(gnt), .data_rvalid_ip(rvalid), .data_rdata_ip(rd_i),
      .lsu_rdata_op(lsu_rdata_op), .lsu_valid_op(lsu_valid_op),
      .lsu_err_op(lsu_err_op), .lsu_busy_op(lsu_busy_op)
   );

   function automatic obs_t model(input logic we, input logic [1:0] sz, input logic sg,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                  input int gd, input int rvd);
      obs_t m;
      bit mis;
      logic [31:0] v;
      int sh;
      m = '{default: 0};
      m.stable = 1;
      mis = (sz == 2'b01 && a[0]) || (sz >= 2 && (a % 4) != 0);
      if (TRAP && mis) begin
         m.lat = 0; m.err = 1'b1; m.rdata = 0;
      end else begin
         m.addr = a & ~32'd3;
         m.we   = we;
         if (sz == 0) begin
            m.be = 4'(1 << (a % 4)); m.wd = (wd & 32'hFF) * 32'h0101_0101;
         end else if (sz == 1) begin
            m.be = 4'(3 << (2 * ((a / 2) % 2))); m.wd = (wd & 32'hFFFF) * 32'h0001_0001;
         end else begin
            m.be = 4'hF; m.wd = wd;
         end
         if (gd >= int'(TMO)) begin
            m.reqc = TMO; m.lat = TMO; m.err = 1'b1; m.rdata = 0;
         end else if (rvd >= int'(TMO)) begin
            m.reqc = gd + 1; m.lat = gd + 1 + TMO; m.err = 1'b1; m.rdata = 0;
         end else begin
            m.reqc = gd + 1; m.lat = gd + rvd + 2; m.err = 1'b0;
            if (we) v = 0;
            else if (sz == 0) begin
               sh = 8 * int'(a % 4);
               v = (rd >> sh) & 32'hFF;
               if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 1) begin
               sh = 16 * int'((a / 2) % 2);
               v = (rd >> sh) & 32'hFFFF;
               if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else v = rd;
            m.rdata = v;
         end
      end
      m.post_rdata = m.rdata;
      m.post_err   = m.err;
      return m;
   endfunction

   task automatic txn(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input int gd, input int rvd,
                      input bit noise, output obs_t o);
      o = '{default: 0};
      o.stable = 1;
      o.lat = -1;
      @(negedge clk);
      en = 1'b1; av = 1'b1; we_i = we; sz_i = sz; sg_i = sg; alu = a; wd_i = wd; rd_i = rd;
      @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (lsu_valid_op) begin
            o.lat = k; o.rdata = lsu_rdata_op; o.err = lsu_err_op;
            if (lsu_busy_op) o.busy_bad++;
            break;
         end
         if (!lsu_busy_op) o.busy_bad++;
         if (data_req_op) begin
            if (o.reqc == 0) begin
               o.addr = data_addr_op; o.be = data_be_op; o.wd = data_wdata_op; o.we = data_we_op;
            end else if (o.addr !== data_addr_op || o.be !== data_be_op ||
                         o.wd !== data_wdata_op || o.we !== data_we_op) begin
               o.stable = 0;
            end
            o.reqc++;
         end
         if (k == 0) begin
            en = noise; av = noise; alu = $urandom; wd_i = $urandom; we_i = ~we;
         end
         gnt    = (k == gd) || (k > gd && noise && $urandom_range(1, 0) == 1);
         rvalid = (k == gd + 1 + rvd) || (k <= gd && noise && $urandom_range(1, 0) == 1);
      end
      en = 1'b0; av = 1'b0; gnt = 1'b0; rvalid = 1'b0;
      @(negedge clk);
      o.post_valid = lsu_valid_op; o.post_rdata = lsu_rdata_op; o.post_err = lsu_err_op;
   endtask

   task automatic test_reset;
      #1;
      vec++;
      if ({data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
           lsu_valid_op, lsu_err_op, lsu_rdata_op, lsu_busy_op} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got addr=%h be=%h wd=%h rdata=%h req=%b valid=%b err=%b busy=%b",
                  data_addr_op, data_be_op, data_wdata_op, lsu_rdata_op, data_req_op,
                  lsu_valid_op, lsu_err_op, lsu_busy_op);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_word_load;
      obs_t o;
      txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, o);
      vec++;
      if ({o.reqc, o.addr, o.be} !== {32'd1, 32'h100, 4'hF}) begin
         errs++;
         $display("FAIL word_load_bus: got req_cycles=%0d addr=%h be=%h want 1 00000100 f", o.reqc, o.addr, o.be);
      end
      vec++;
      if ({o.lat, o.rdata, o.err} !== {32'd2, 32'hDEADBEEF, 1'b0}) begin
         errs++;
         $display("FAIL word_load_done: got lat=%0d rdata=%h err=%b want 2 deadbeef 0", o.lat, o.rdata, o.err);
      end
      vec++;
      if (o.post_valid !== 1'b0 || o.post_rdata !== 32'hDEADBEEF) begin
         errs++;
         $display("FAIL word_load_pulse: got valid=%b rdata=%h want 0 deadbeef", o.post_valid, o.post_rdata);
      end
   endtask

   task automatic test_byte_load_sign;
      obs_t o;
      txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 1, 1, 1'b0, o);
      vec++;
      if (o.rdata !== 32'hFFFFFF80 || o.err !== 1'b0) begin
         errs++;
         $display("FAIL byte_load_signed: got %h err=%b want ffffff80 0", o.rdata, o.err);
      end
      txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 2, 1'b0, o);
      vec++;
      if (o.rdata !== 32'h00000080) begin
         errs++;
         $display("FAIL byte_load_unsigned: got %h want 00000080", o.rdata);
      end
   endtask

   task automatic test_half_store;
      obs_t o;
      txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'hFFFF_FFFF, 3, 0, 1'b1, o);
      vec++;
      if ({o.reqc, o.be, o.wd, o.we, o.stable} !== {32'd4, 4'b1100, 32'hABCDABCD, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL half_store_bus: got req_cycles=%0d be=%b wd=%h we=%b stable=%b want 4 1100 abcdabcd 1 1",
                  o.reqc, o.be, o.wd, o.we, o.stable);
      end
      vec++;
      if ({o.lat, o.rdata, o.err} !== {32'd5, 32'h0, 1'b0}) begin
         errs++;
         $display("FAIL half_store_done: got lat=%0d rdata=%h err=%b want 5 00000000 0", o.lat, o.rdata, o.err);
      end
   endtask

   task automatic test_timeout;
      obs_t o;
      int seen;
      txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1, 20, 0, 1'b0, o);
      vec++;
      if ({o.reqc, o.lat, o.err, o.rdata} !== {32'd4, 32'd4, 1'b1, 32'h0}) begin
         errs++;
         $display("FAIL gnt_timeout: got req_cycles=%0d lat=%0d err=%b rdata=%h want 4 4 1 0",
                  o.reqc, o.lat, o.err, o.rdata);
      end
      seen = 0;
      gnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (data_req_op || lsu_valid_op || lsu_busy_op) seen++;
      end
      gnt = 1'b0;
      vec++;
      if (seen !== 0) begin
         errs++;
         $display("FAIL late_gnt_ignored: got %0d active cycles want 0", seen);
      end
      txn(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h2, 0, 20, 1'b0, o);
      vec++;
      if ({o.lat, o.err, o.post_err} !== {32'd5, 1'b1, 1'b1}) begin
         errs++;
         $display("FAIL rvalid_timeout: got lat=%0d err=%b held_err=%b want 5 1 1", o.lat, o.err, o.post_err);
      end
      txn(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 32'h5A5A_0F0F, 3, 3, 1'b0, o);
      vec++;
      if ({o.lat, o.err, o.rdata} !== {32'd8, 1'b0, 32'h5A5A_0F0F}) begin
         errs++;
         $display("FAIL event_beats_timeout: got lat=%0d err=%b rdata=%h want 8 0 5a5a0f0f", o.lat, o.err, o.rdata);
      end
   endtask

   task automatic test_misalign;
      obs_t o;
      txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h11223344, 0, 0, 1'b0, o);
      vec++;
      if ({o.reqc, o.addr} !== {(TRAP ? 32'd0 : 32'd1), (TRAP ? 32'h0 : 32'h100)}) begin
         errs++;
         $display("FAIL misalign_bus: got req_cycles=%0d addr=%h trap=%b", o.reqc, o.addr, TRAP);
      end
      vec++;
      if ({o.lat, o.err, o.rdata} !== {(TRAP ? 32'd0 : 32'd2), TRAP, (TRAP ? 32'h0 : 32'h11223344)}) begin
         errs++;
         $display("FAIL misalign_done: got lat=%0d err=%b rdata=%h trap=%b", o.lat, o.err, o.rdata, TRAP);
      end
   endtask

   task automatic test_reset_mid;
      obs_t o;
      int seen;
      @(negedge clk);
      en = 1'b1; av = 1'b1; we_i = 1'b0; sz_i = 2'b10; alu = 32'h300; rd_i = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0; av = 1'b0; gnt = 1'b1;
      @(negedge clk);
      gnt = 1'b0;
      vec++;
      if (lsu_busy_op !== 1'b1 || data_req_op !== 1'b0) begin
         errs++;
         $display("FAIL wait_rvalid_state: got busy=%b req=%b want 1 0", lsu_busy_op, data_req_op);
      end
      reset = 1'b0;
      #1;
      vec++;
      if ({data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op,
           lsu_valid_op, lsu_err_op, lsu_rdata_op, lsu_busy_op} !== '0) begin
         errs++;
         $display("FAIL reset_mid_outputs: got addr=%h be=%h busy=%b valid=%b", data_addr_op, data_be_op,
                  lsu_busy_op, lsu_valid_op);
      end
      @(negedge clk);
      reset = 1'b1; rvalid = 1'b1;
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rvalid = 1'b0;
         if (lsu_valid_op || lsu_busy_op) seen++;
      end
      vec++;
      if (seen !== 0) begin
         errs++;
         $display("FAIL late_rvalid_ignored: got %0d active cycles want 0", seen);
      end
      txn(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0, o);
      vec++;
      if ({o.lat, o.rdata, o.err, o.addr} !== {32'd2, 32'hCAFE_F00D, 1'b0, 32'h400}) begin
         errs++;
         $display("FAIL after_reset_txn: got lat=%0d rdata=%h err=%b addr=%h want 2 cafef00d 0 00000400",
                  o.lat, o.rdata, o.err, o.addr);
      end
   endtask

   task automatic test_random;
      obs_t o, e;
      logic we, sg;
      logic [1:0] sz;
      logic [31:0] a, wd, rd;
      int gd, rvd;
      bit noise;
      for (int n = 0; n < 60; n++) begin
         we = 1'($urandom_range(1, 0)); sg = 1'($urandom_range(1, 0)); sz = 2'($urandom_range(3, 0));
         a = $urandom; wd = $urandom; rd = $urandom;
         gd  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(6, 4)) : int'($urandom_range(3, 0));
         rvd = ($urandom_range(7, 0) == 0) ? int'($urandom_range(6, 4)) : int'($urandom_range(3, 0));
         noise = 1'($urandom_range(1, 0));
         e = model(we, sz, sg, a, wd, rd, gd, rvd);
         txn(we, sz, sg, a, wd, rd, gd, rvd, noise, o);
         vec++;
         if ({o.reqc, o.addr, o.be, o.wd, o.we, o.stable} !== {e.reqc, e.addr, e.be, e.wd, e.we, e.stable}) begin
            errs++;
            $display("FAIL rand_bus[%0d]: got req_cycles=%0d addr=%h be=%h wd=%h we=%b stable=%b want %0d %h %h %h %b 1",
                     n, o.reqc, o.addr, o.be, o.wd, o.we, o.stable, e.reqc, e.addr, e.be, e.wd, e.we);
         end
         vec++;
         if ({o.lat, o.rdata, o.err} !== {e.lat, e.rdata, e.err}) begin
            errs++;
            $display("FAIL rand_done[%0d]: got lat=%0d rdata=%h err=%b want %0d %h %b",
                     n, o.lat, o.rdata, o.err, e.lat, e.rdata, e.err);
         end
         vec++;
         if ({o.busy_bad, o.post_valid, o.post_rdata, o.post_err} !==
             {32'd0, 1'b0, e.post_rdata, e.post_err}) begin
            errs++;
            $display("FAIL rand_busy_hold[%0d]: got busy_bad=%0d valid=%b rdata=%h err=%b want 0 0 %h %b",
                     n, o.busy_bad, o.post_valid, o.post_rdata, o.post_err, e.post_rdata, e.post_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load_sign();
      test_half_store();
      test_timeout();
      test_misalign();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles spent in one bus-wait state before abort (range 1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port lsu_enable_ip  input  1  decode marks the current instruction as a load/store.
REQ-005 SHALL have ports lsu_we_ip  input  1  (1=store); lsu_size_ip  input  2  (00 byte, 01 half, 10/11 word); lsu_sign_ext_ip  input  1  (load sign-extend).
REQ-006 SHALL have ports alu_result_ip  input  32  effective address; alu_valid_ip  input  1  address valid.
REQ-007 SHALL have port lsu_wdata_ip  input  32  store data, LSB-aligned.
REQ-008 SHALL have ports data_req_op  output  1; data_addr_op  output  32; data_we_op  output  1; data_be_op  output  4; data_wdata_op  output  32.
REQ-009 SHALL have ports data_gnt_ip  input  1; data_rvalid_ip  input  1; data_rdata_ip  input  32.
REQ-010 SHALL have ports lsu_rdata_op  output  32; lsu_valid_op  output  1  one-cycle completion pulse; lsu_err_op  output  1; lsu_busy_op  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RVALID.
REQ-012 IDLE: lsu_enable_ip=1 and alu_valid_ip=1 at an edge SHALL capture address, we, size, sign, wdata and enter WAIT_GNT.
REQ-013 WAIT_GNT: data_req_op=1, with data_addr_op={addr[31:2],2'b00} and data_we_op/data_be_op/data_wdata_op held constant until the grant.
REQ-014 data_gnt_ip=1 in WAIT_GNT SHALL move to WAIT_RVALID; data_req_op=0 from the next cycle.
REQ-015 data_rvalid_ip=1 in WAIT_RVALID SHALL return to IDLE and pulse lsu_valid_op=1, lsu_err_op=0 in the following cycle.
REQ-016 data_rvalid_ip outside WAIT_RVALID and data_gnt_ip outside WAIT_GNT SHALL be ignored.
REQ-017 Minimum latency: accept at edge N, req high in cycle N..N+1, gnt in cycle N+1, rvalid in cycle N+2, lsu_valid_op high in cycle N+3.
REQ-018 lsu_busy_op SHALL be 1 whenever state != IDLE; new requests while busy SHALL be ignored.
REQ-019 Byte store: be=4'b0001<<addr[1:0], wdata=byte replicated x4; half: be=4'b0011<<{addr[1],1'b0}, wdata=half replicated x2; word: be=4'b1111, wdata unchanged.
REQ-020 Load SHALL select byte addr[1:0] or half addr[1] from data_rdata_ip and zero- or sign-extend to 32 bits per lsu_sign_ext_ip; word is passed unchanged.
REQ-021 Store completion SHALL drive lsu_rdata_op=0.
REQ-022 An 8-bit counter SHALL clear on every state entry and increment each cycle in WAIT_GNT/WAIT_RVALID.
REQ-023 A counter value of TIMEOUT_CYCLES without the awaited event SHALL force IDLE, drop data_req_op, and pulse lsu_valid_op=1, lsu_err_op=1, lsu_rdata_op=0.
REQ-024 An awaited event in the same cycle the timeout is reached SHALL win over the timeout.
REQ-025 lsu_rdata_op and lsu_err_op SHALL hold their last values between completion pulses.

Reset
REQ-026 reset=0 SHALL immediately force IDLE, counter 0, data_req_op=0, data_we_op=0, data_be_op=0, data_addr_op=0, data_wdata_op=0, lsu_valid_op=0, lsu_err_op=0, lsu_rdata_op=0, lsu_busy_op=0.
REQ-027 Reset mid-transaction SHALL abandon the access without a completion pulse; a late data_rvalid_ip SHALL be ignored.

Configuration
REQ-028 With LSU_MISALIGN_TRAP_EN defined, a misaligned access (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no bus request, stay IDLE, and pulse lsu_valid_op=1, lsu_err_op=1, lsu_rdata_op=0 in the next cycle.
REQ-029 Without LSU_MISALIGN_TRAP_EN, misaligned low address bits SHALL be forced to alignment (half: addr[0]=0; word: addr[1:0]=0) and the access SHALL proceed normally with no error.

Verification
REQ-030 Word load addr 0x100, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF -> data_addr_op=0x100, data_be_op=4'hF, lsu_rdata_op=0xDEADBEEF, lsu_valid_op at N+3.
REQ-031 Signed byte load addr 0x103, rdata 0x80FFFFFF -> lsu_rdata_op=0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-032 Half store addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles -> req held 4 cycles, data_be_op=4'b1100, data_wdata_op=0xABCDABCD stable throughout.
REQ-033 TIMEOUT_CYCLES=4, no gnt -> req drops and lsu_valid_op=1, lsu_err_op=1 after 4 wait cycles; a later gnt is ignored.
REQ-034 Word load addr 0x101: with LSU_MISALIGN_TRAP_EN -> no data_req_op, err pulse next cycle; without it -> data_addr_op=0x100, normal completion.
REQ-035 reset asserted during WAIT_RVALID, then rvalid -> outputs zero immediately, no lsu_valid_op pulse, next request accepted normally.
